// File: rtl/seq_booth_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, signed or unsigned per
// transaction, valid/ready handshakes on both sides.
module seq_booth_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int unsigned W2   = WIDTH + 2;
  localparam int unsigned N    = W2 / 2;
  localparam int unsigned CntW = $clog2(N);

  if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("seq_booth_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [W2-1:0]       mcand_q;
  logic [W2+1:0]       hi_q;
  logic [W2-1:0]       lo_q;
  logic                bprev_q;
  logic [CntW-1:0]     cnt_q;
  logic [2*WIDTH-1:0]  prod_q;

  logic [2:0]          win;
  logic [W2+1:0]       mcand_ext;
  logic [W2+1:0]       pp;
  logic [W2+1:0]       sum;
  logic [2*W2+1:0]     shifted;
  logic                last;

  // Datapath: {hi, lo} is the running product; lo starts as the multiplier and shifts out
  // two bits per step, so the Booth window is always lo[1:0] plus the last bit shifted out.
  always_comb begin
    win       = {lo_q[1:0], bprev_q};
    mcand_ext = {{2{mcand_q[W2-1]}}, mcand_q};
    pp        = '0;
    unique case (win)
      3'b000, 3'b111: pp = '0;
      3'b001, 3'b010: pp = mcand_ext;
      3'b011:         pp = mcand_ext << 1;
      3'b100:         pp = -(mcand_ext << 1);
      3'b101, 3'b110: pp = -mcand_ext;
      default:        pp = '0;
    endcase
    sum     = hi_q + pp;
    shifted = $signed({sum, lo_q}) >>> 2;
    last    = (cnt_q == CntW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bprev_q <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Zero-extension lets unsigned operands run through the signed datapath.
            mcand_q <= {{2{signed_mode & a[WIDTH-1]}}, a};
            lo_q    <= {{2{signed_mode & b[WIDTH-1]}}, b};
            hi_q    <= '0;
            bprev_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StCalc: begin
          hi_q    <= shifted[2*W2+1:W2];
          lo_q    <= shifted[W2-1:0];
          bprev_q <= lo_q[1];
          cnt_q   <= cnt_q + CntW'(1);
          if (last) begin
            prod_q <= shifted[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StCalc;
      StCalc:  if (last)      state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  assign prod = prod_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Bench for seq_booth_mult: WIDTH=8 and WIDTH=16 instances run side by side, each with a
// driver and a scoreboard monitor checking results against plain-arithmetic products.
module tb_seq_booth_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gw
    localparam int W = (g == 0) ? 8 : 16;
    localparam int N = (W + 2) / 2;

    logic           rst_n, in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] prod;
    logic           done = 1'b0;

    seq_booth_mult #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .prod        (prod),
      .busy        (busy)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic m);
      logic signed [2*W-1:0] sx, sy;
      sx = m ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      sy = m ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      return sx * sy;
    endfunction

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];

    // Monitor: records accepts, then checks latency, value and hold of each result.
    initial begin
      logic [2*W-1:0] held;
      bit prev_ov, prev_hs;
      held = '0;
      prev_ov = 1'b0;
      prev_hs = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
          held = '0;
          prev_ov = 1'b0;
          prev_hs = 1'b0;
        end else begin
          check(busy != in_ready, "busy_vs_in_ready", busy, !in_ready);
          check(!(in_ready && out_valid), "ready_valid_exclusive", {in_ready, out_valid}, 0);
          if (prev_hs) check(in_ready && !out_valid, "idle_after_result",
                             {in_ready, out_valid}, 2'b10);
          if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, signed_mode));
            acc_q.push_back(cyc + 1);
          end
          if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
              check(1'b0, "spurious_result", prod, 0);
            end else begin
              check(cyc - acc_q[0] == N, "latency", cyc - acc_q[0], N);
              check(prod == exp_q[0], "prod", prod, exp_q[0]);
            end
            held = prod;
          end else begin
            check(prod == held, "prod_hold", prod, held);
          end
          prev_hs = out_valid && out_ready;
          if (prev_hs && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
          prev_ov = out_valid;
        end
      end
    end

    task automatic reset_seq();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      signed_mode = 1'b0;
      repeat (3) @(negedge clk);
      check({in_ready, out_valid, busy} == 3'b100, "reset_flags",
            {in_ready, out_valid, busy}, 3'b100);
      check(prod == '0, "reset_prod", prod, 0);
      rst_n = 1'b1;
    endtask

    // Presents operands and returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      bit ok = 1'b0;
      @(negedge clk);
      a = x;
      b = y;
      signed_mode = m;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
        #1;
        if (in_ready) ok = 1'b1;
        else @(negedge clk);
      end
      check(ok, "accept_timeout", ok, 1);
      if (ok) @(posedge clk);
    endtask

    // Scrambles operands while busy, applies `stall` cycles of backpressure, then takes the result.
    task automatic finish(input int stall, input bit force_iv, input bit has_exp,
                          input logic [2*W-1:0] expv);
      bit hs = 1'b0;
      for (int i = 0; i < 100 && !hs; i++) begin
        @(negedge clk);
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        in_valid = force_iv | 1'($urandom);
        if (out_valid && stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = out_valid | 1'($urandom);
        end
        if (out_valid && out_ready) begin
          hs = 1'b1;
          if (has_exp) check(prod == expv, "directed_prod", prod, expv);
          @(posedge clk);
        end
      end
      if (!hs) check(1'b0, "result_timeout", 0, 1);
      in_valid = 1'b0;
    endtask

    task automatic regress(input int n);
      for (int i = 0; i < n; i++) begin
        issue(W'($urandom), W'($urandom), 1'($urandom));
        finish(int'($urandom_range(0, 2)), 1'b0, 1'b0, '0);
      end
    endtask

    if (g == 0) begin : g_dir
      initial begin
        reset_seq();
        issue(8'hFF, 8'hFF, 1'b0); finish(0, 1'b0, 1'b1, 16'hFE01);
        issue(8'hFF, 8'hFF, 1'b1); finish(0, 1'b0, 1'b1, 16'h0001);
        issue(8'h80, 8'h80, 1'b1); finish(0, 1'b0, 1'b1, 16'h4000);
        issue(8'h80, 8'h7F, 1'b1); finish(0, 1'b0, 1'b1, 16'hC080);
        issue(8'h80, 8'h02, 1'b0); finish(0, 1'b0, 1'b1, 16'h0100);
        issue(8'hAA, 8'h55, 1'b0); finish(3, 1'b1, 1'b1, 16'h3872);
        // Reset two cycles into CALC discards the operation at once.
        issue(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check({in_ready, out_valid, busy} == 3'b100, "midcalc_reset_flags",
              {in_ready, out_valid, busy}, 3'b100);
        check(prod == '0, "midcalc_reset_prod", prod, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h03, 8'h05, 1'b0); finish(0, 1'b0, 1'b1, 16'h000F);
        regress(1000);
        done = 1'b1;
      end
    end else begin : g_dir
      initial begin
        reset_seq();
        issue(16'hFFFF, 16'hFFFF, 1'b0); finish(0, 1'b0, 1'b1, 32'hFFFE0001);
        issue(16'h8000, 16'h8000, 1'b1); finish(1, 1'b0, 1'b1, 32'h40000000);
        regress(1000);
        done = 1'b1;
      end
    end
  end

  initial begin
    while (!(gw[0].done && gw[1].done) && cyc < 90000) @(posedge clk);
    check(gw[0].done && gw[1].done, "run_completion", {gw[0].done, gw[1].done}, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
